screen_fb_arbiter: RTL and testbench

//   Shares the single column-write port of the Nokia 5110 screen_controller between two requesters
//   (e.g. text renderer, UART image loader) with round-robin arbitration. Adds a clear engine that

---
 rtl/screen_fb_arbiter.sv | 167 ++++++++++++++++
 tb/tb_screen_fb_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/screen_fb_arbiter.sv
// Column-write port arbiter for the Nokia 5110 screen_controller: round-robin between two
// requesters plus a full-screen clear engine that owns the port for NUM_COLUMNS cycles.
module screen_fb_arbiter #(
  parameter int                 NUM_COLUMNS     = 84,
  parameter int                 ADDR_W          = 7,
  parameter int                 DATA_W          = 48,
  parameter logic [DATA_W-1:0]  CLEAR_PATTERN   = '0,
  parameter bit                 FREEZE_ON_CLEAR = 1'b1
) (
  input  logic              clk_main,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] data0,
  output logic              gnt0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt1,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              range_err,
  output logic [ADDR_W-1:0] scr_address,
  output logic [DATA_W-1:0] scr_data,
  output logic              scr_wr_en,
  output logic              scr_enable
);

  typedef enum logic {ST_ARB, ST_CLEAR} state_t;

  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(NUM_COLUMNS - 1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_count;
  logic [1:0]          r_gnt;
  logic                r_last;
  logic                r_wr_en;
  logic                r_busy;
  logic                r_range_err;
  logic                r_enable;
  logic [ADDR_W-1:0]   r_address;
  logic [DATA_W-1:0]   r_data;

  state_t              w_state_next;
  logic [ADDR_W-1:0]   w_count_next;
  logic [1:0]          w_gnt_next;
  logic                w_last_next;
  logic                w_wr_en_next;
  logic                w_busy_next;
  logic                w_range_err_next;
  logic                w_enable_next;
  logic [ADDR_W-1:0]   w_address_next;
  logic [DATA_W-1:0]   w_data_next;
  logic                w_sel;

  logic [1:0]          w_req;
  logic [ADDR_W-1:0]   w_addr [2];
  logic [DATA_W-1:0]   w_data [2];
  logic [1:0]          w_elig;
  logic [1:0]          w_in_range;

  assign w_req     = {req1, req0};
  assign w_addr[0] = addr0;
  assign w_addr[1] = addr1;
  assign w_data[0] = data0;
  assign w_data[1] = data1;

  // A requester granted on the previous edge may still hold req high; skip it once.
  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    assign w_elig[gi]     = w_req[gi] & ~r_gnt[gi];
    assign w_in_range[gi] = (int'(w_addr[gi]) < NUM_COLUMNS);
  end

  always_comb begin
    w_state_next     = r_state;
    w_count_next     = r_count;
    w_gnt_next       = '0;
    w_last_next      = r_last;
    w_wr_en_next     = 1'b0;
    w_busy_next      = 1'b0;
    w_range_err_next = 1'b0;
    w_address_next   = r_address;
    w_data_next      = r_data;
    w_sel            = 1'b0;

    case (r_state)
      ST_ARB: begin
        if (clear_start) begin
          // The sampling edge already issues column 0, so the sweep has no dead cycle.
          w_wr_en_next   = 1'b1;
          w_busy_next    = 1'b1;
          w_address_next = '0;
          w_data_next    = CLEAR_PATTERN;
          if (NUM_COLUMNS > 1) begin
            w_state_next = ST_CLEAR;
            w_count_next = ADDR_W'(1);
          end
        end else if (|w_elig) begin
          w_sel = (&w_elig) ? ~r_last : w_elig[1];
          w_gnt_next[w_sel] = 1'b1;
          w_last_next       = w_sel;
          if (w_in_range[w_sel]) begin
            w_wr_en_next   = 1'b1;
            w_address_next = w_addr[w_sel];
            w_data_next    = w_data[w_sel];
          end else begin
            w_range_err_next = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        w_wr_en_next   = 1'b1;
        w_busy_next    = 1'b1;
        w_address_next = r_count;
        w_data_next    = CLEAR_PATTERN;
        if (r_count == LAST_COL) begin
          w_state_next = ST_ARB;
          w_count_next = '0;
        end else begin
          w_count_next = r_count + ADDR_W'(1);
        end
      end
      default: begin
        w_state_next = ST_ARB;
        w_count_next = '0;
      end
    endcase

    w_enable_next = !(FREEZE_ON_CLEAR && w_busy_next);
  end

  always_ff @(posedge clk_main) begin
    if (rst) begin
      r_state     <= ST_ARB;
      r_count     <= '0;
      r_gnt       <= '0;
      r_last      <= 1'b1;
      r_wr_en     <= 1'b0;
      r_busy      <= 1'b0;
      r_range_err <= 1'b0;
      r_enable    <= 1'b0;
      r_address   <= '0;
      r_data      <= '0;
    end else begin
      r_state     <= w_state_next;
      r_count     <= w_count_next;
      r_gnt       <= w_gnt_next;
      r_last      <= w_last_next;
      r_wr_en     <= w_wr_en_next;
      r_busy      <= w_busy_next;
      r_range_err <= w_range_err_next;
      r_enable    <= w_enable_next;
      r_address   <= w_address_next;
      r_data      <= w_data_next;
    end
  end

  assign gnt0        = r_gnt[0];
  assign gnt1        = r_gnt[1];
  assign clear_busy  = r_busy;
  assign range_err   = r_range_err;
  assign scr_address = r_address;
  assign scr_data    = r_data;
  assign scr_wr_en   = r_wr_en;
  assign scr_enable  = r_enable;

endmodule

// File: tb/tb_screen_fb_arbiter.sv
// Directed bench for screen_fb_arbiter: expected per-cycle outputs are queued as stimulus is
// driven and compared one cycle later against the registered DUT outputs.
module tb_screen_fb_arbiter;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 48;
  localparam int NCOL   = 84;

  typedef struct packed {
    logic              gnt0;
    logic              gnt1;
    logic              wr_en;
    logic              rerr;
    logic              busy;
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } obs_t;

  logic              clk_main = 1'b0;
  logic              rst = 1'b1;
  logic              req0 = 1'b0, req1 = 1'b0, clear_start = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic [DATA_W-1:0] data0 = '0, data1 = '0;
  logic              gnt0, gnt1, clear_busy, range_err, scr_wr_en, scr_enable;
  logic [ADDR_W-1:0] scr_address;
  logic [DATA_W-1:0] scr_data;

  int   tests_run = 0;
  int   tests_failed = 0;
  obs_t exp_q[$];
  string tag_q[$];

  // Values the screen port should still be holding when idle.
  logic [ADDR_W-1:0] hold_addr = '0;
  logic [DATA_W-1:0] hold_data = '0;

  screen_fb_arbiter dut (
    .clk_main(clk_main), .rst(rst),
    .req0(req0), .addr0(addr0), .data0(data0), .gnt0(gnt0),
    .req1(req1), .addr1(addr1), .data1(data1), .gnt1(gnt1),
    .clear_start(clear_start), .clear_busy(clear_busy), .range_err(range_err),
    .scr_address(scr_address), .scr_data(scr_data),
    .scr_wr_en(scr_wr_en), .scr_enable(scr_enable)
  );

  always #5 clk_main = ~clk_main;

  function automatic obs_t mk(input logic g0, input logic g1, input logic wr, input logic re,
                              input logic bz, input logic en, input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] d);
    obs_t o;
    o = {g0, g1, wr, re, bz, en, a, d};
    return o;
  endfunction

  function automatic obs_t idle();
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, hold_addr, hold_data);
  endfunction

  // Queue the expectation for the edge about to happen, then compare just after it.
  task automatic step(input obs_t e, input string tag);
    obs_t  obs;
    obs_t  want;
    string t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk_main);
    #1;
    obs  = {gnt0, gnt1, scr_wr_en, range_err, clear_busy, scr_enable, scr_address, scr_data};
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    tests_run++;
    assert (obs === want) else begin
      tests_failed++;
      $error("FAIL %s: observed g0=%b g1=%b wr=%b rerr=%b busy=%b en=%b addr=%0d data=%h expected g0=%b g1=%b wr=%b rerr=%b busy=%b en=%b addr=%0d data=%h",
             t, obs.gnt0, obs.gnt1, obs.wr_en, obs.rerr, obs.busy, obs.en, obs.addr, obs.data,
             want.gnt0, want.gnt1, want.wr_en, want.rerr, want.busy, want.en, want.addr, want.data);
    end
    $display("[TB] %s g0=%b g1=%b wr=%b rerr=%b busy=%b en=%b addr=%0d data=%h",
             t, obs.gnt0, obs.gnt1, obs.wr_en, obs.rerr, obs.busy, obs.en, obs.addr, obs.data);
  endtask

  initial begin
    logic [DATA_W-1:0] d0, d1;

    // Reset held for 3 cycles: everything low, including scr_enable.
    for (int i = 0; i < 3; i++) step('0, "reset");
    rst = 1'b0;
    step(idle(), "reset_release");

    // Contention: both requesters held, fresh data after every grant, req0 wins first.
    req0 = 1'b1; addr0 = 7'd10; d0 = 48'hA000_0000_0000; data0 = d0;
    req1 = 1'b1; addr1 = 7'd20; d1 = 48'hB000_0000_0000; data1 = d1;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) begin
        step(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 7'd10, d0), "contend_gnt0");
        hold_addr = 7'd10; hold_data = d0;
        d0 = d0 + 48'd1; data0 = d0;
      end else begin
        step(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 7'd20, d1), "contend_gnt1");
        hold_addr = 7'd20; hold_data = d1;
        d1 = d1 + 48'd1; data1 = d1;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    step(idle(), "contend_idle");

    // Single write; requester keeps req high through its grant cycle: no second grant.
    req0 = 1'b1; addr0 = 7'd5; data0 = 48'hFFFF_0000_00FF;
    step(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 7'd5, 48'hFFFF_0000_00FF), "single_gnt0");
    hold_addr = 7'd5; hold_data = 48'hFFFF_0000_00FF;
    step(idle(), "single_no_double");
    req0 = 1'b0;
    step(idle(), "single_idle");

    // Out-of-range address: grant pulses, no write, port holds previous values.
    req1 = 1'b1; addr1 = 7'd84; data1 = 48'h1234_5678_9ABC;
    step(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, hold_addr, hold_data), "range_84");
    req1 = 1'b0;
    step(idle(), "range_idle");

    // Last valid column is an ordinary write.
    req0 = 1'b1; addr0 = 7'd83; data0 = 48'h0000_0000_0083;
    step(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 7'd83, 48'h83), "range_83");
    hold_addr = 7'd83; hold_data = 48'h83;
    req0 = 1'b0;
    step(idle(), "range83_idle");

    // Clear with req0 pending on the same edge: clear wins, req0 served after the sweep.
    req0 = 1'b1; addr0 = 7'd7; data0 = 48'hCAFE_F00D_0007;
    clear_start = 1'b1;
    step(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 7'd0, '0), "clear_col");
    clear_start = 1'b0;
    for (int c = 1; c < NCOL; c++) begin
      clear_start = (c == 30);   // ignored while clearing
      step(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ADDR_W'(c), '0), "clear_col");
    end
    clear_start = 1'b0;
    step(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 7'd7, 48'hCAFE_F00D_0007), "clear_then_gnt0");
    hold_addr = 7'd7; hold_data = 48'hCAFE_F00D_0007;
    req0 = 1'b0;
    step(idle(), "post_clear_idle");

    // Reset in the middle of a clear aborts it; a new clear starts again at column 0.
    clear_start = 1'b1;
    step(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 7'd0, '0), "clear2_col");
    clear_start = 1'b0;
    for (int c = 1; c <= 40; c++)
      step(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ADDR_W'(c), '0), "clear2_col");
    rst = 1'b1;
    step('0, "midclear_reset");
    rst = 1'b0;
    hold_addr = '0; hold_data = '0;
    step(idle(), "midclear_release");
    step(idle(), "midclear_no_resume");
    clear_start = 1'b1;
    step(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 7'd0, '0), "clear3_restart");
    clear_start = 1'b0;
    for (int c = 1; c <= 3; c++)
      step(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ADDR_W'(c), '0), "clear3_col");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
